// File: rtl/spn_block_transpose.sv
// Ping-pong PARA x PARA block transposer: fills one bank row-by-row from input beats
// while the other bank drains column-by-column, returning lane-parallel data to natural order.
module spn_block_transpose #(
    parameter int DATA_WIDTH = 32,
    parameter int PARA       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] input_stream  [PARA-1:0],
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] output_stream [PARA-1:0],
    output logic                  valid_out,
    output logic                  block_start
);

    localparam int CNT_W = $clog2(PARA);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PARA - 1);

    typedef enum logic {
        IDLE,
        DRAIN
    } rd_state_e;

    logic [DATA_WIDTH-1:0] mem_q [2][PARA][PARA];

    logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
    logic                  wr_bank_q, wr_bank_d;
    logic                  bank_full;

    rd_state_e             state_q;
    logic [CNT_W-1:0]      rd_cnt_q;
    logic                  rd_bank_q;
    logic [DATA_WIDTH-1:0] out_q [PARA-1:0];
    logic                  valid_q;
    logic                  start_q;

    // NOTE: every signal gets its default before any branch, so no path leaves it unassigned (no latch).
    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q;
        bank_full = 1'b0;
        if (valid_in) begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
            if (wr_cnt_q == LAST) begin
                wr_bank_d = ~wr_bank_q;
                bank_full = 1'b1;
            end
        end
    end

    // NOTE: the buffer RAM is deliberately not reset; the counters alone decide what is valid.
    always_ff @(posedge clk) begin
        if (valid_in && !rst) begin
            for (int l = 0; l < PARA; l++) begin
                mem_q[wr_bank_q][wr_cnt_q][l] <= input_stream[l];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q  <= '0;
            wr_bank_q <= 1'b0;
            state_q   <= IDLE;
            rd_cnt_q  <= '0;
            rd_bank_q <= 1'b0;
            valid_q   <= 1'b0;
            start_q   <= 1'b0;
            for (int j = 0; j < PARA; j++) begin
                out_q[j] <= '0;
            end
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            wr_bank_q <= wr_bank_d;
            valid_q   <= 1'b0;
            start_q   <= 1'b0;
            for (int j = 0; j < PARA; j++) begin
                out_q[j] <= '0;
            end

            case (state_q)
                IDLE: begin
                    if (bank_full) begin
                        state_q   <= DRAIN;
                        rd_bank_q <= wr_bank_q;
                        rd_cnt_q  <= '0;
                    end
                end
                DRAIN: begin
                    valid_q <= 1'b1;
                    start_q <= (rd_cnt_q == '0);
                    for (int j = 0; j < PARA; j++) begin
                        out_q[j] <= mem_q[rd_bank_q][j][rd_cnt_q];
                    end
                    rd_cnt_q <= rd_cnt_q + CNT_W'(1);
                    // A bank completing on the last column chains straight into the next drain.
                    if (rd_cnt_q == LAST) begin
                        if (bank_full) begin
                            rd_bank_q <= wr_bank_q;
                            rd_cnt_q  <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign output_stream = out_q;
    assign valid_out     = valid_q;
    assign block_start   = start_q;

endmodule

// File: tb/tb_spn_block_transpose.sv
// Scoreboard bench for spn_block_transpose at PARA=4 and PARA=32: the driver models blocks
// as plain matrices and queues transposed beats with their due cycle; monitors compare on every cycle.
module tb_spn_block_transpose;

    localparam int DW = 32;

    typedef struct packed {
        logic [31:0][DW-1:0] lanes;
        logic                start;
        logic [31:0]         due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    logic          rst4, vin4, vout4, start4;
    logic [DW-1:0] in4  [3:0];
    logic [DW-1:0] out4 [3:0];

    logic          rst32, vin32, vout32, start32;
    logic [DW-1:0] in32  [31:0];
    logic [DW-1:0] out32 [31:0];

    spn_block_transpose #(.DATA_WIDTH(DW), .PARA(4)) dut4 (
        .clk          (clk),
        .rst          (rst4),
        .input_stream (in4),
        .valid_in     (vin4),
        .output_stream(out4),
        .valid_out    (vout4),
        .block_start  (start4)
    );

    spn_block_transpose #(.DATA_WIDTH(DW), .PARA(32)) dut32 (
        .clk          (clk),
        .rst          (rst32),
        .input_stream (in32),
        .valid_in     (vin32),
        .output_stream(out32),
        .valid_out    (vout32),
        .block_start  (start32)
    );

    // Reference model state: the partially collected block and the expected output beats.
    logic [DW-1:0] blk4  [4][4];
    logic [DW-1:0] blk32 [32][32];
    int            n4  = 0;
    int            n32 = 0;
    exp_t          q4  [$];
    exp_t          q32 [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step4(input bit v, input bit r, input bit rnd, input logic [DW-1:0] base);
        exp_t e;
        vin4 = v;
        rst4 = r;
        for (int l = 0; l < 4; l++) in4[l] = rnd ? DW'($urandom) : base + DW'(l);
        if (r) begin
            n4 = 0;
            while (q4.size() > 0 && int'(q4[$].due) > cyc) void'(q4.pop_back());
        end else if (v) begin
            for (int l = 0; l < 4; l++) blk4[n4][l] = in4[l];
            n4++;
            if (n4 == 4) begin
                for (int k = 0; k < 4; k++) begin
                    e = '0;
                    for (int j = 0; j < 4; j++) e.lanes[j] = blk4[j][k];
                    e.start = (k == 0);
                    e.due   = 32'(cyc + 2 + k);
                    q4.push_back(e);
                end
                n4 = 0;
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic step32(input bit v, input bit rnd, input logic [DW-1:0] base);
        exp_t e;
        vin32 = v;
        for (int l = 0; l < 32; l++) in32[l] = rnd ? DW'($urandom) : base + DW'(l);
        if (v) begin
            for (int l = 0; l < 32; l++) blk32[n32][l] = in32[l];
            n32++;
            if (n32 == 32) begin
                for (int k = 0; k < 32; k++) begin
                    e = '0;
                    for (int j = 0; j < 32; j++) e.lanes[j] = blk32[j][k];
                    e.start = (k == 0);
                    e.due   = 32'(cyc + 2 + k);
                    q32.push_back(e);
                end
                n32 = 0;
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic idle4(input int n);
        repeat (n) step4(1'b0, 1'b0, 1'b0, '0);
    endtask

    exp_t e4_m;
    bit   ev4;
    always @(negedge clk) begin
        if (mon_en) begin
            ev4 = (q4.size() > 0) && (int'(q4[0].due) == cyc);
            check("p4_valid_out", 64'(vout4), 64'(ev4));
            if (ev4) begin
                e4_m = q4.pop_front();
                if (vout4) begin
                    check("p4_block_start", 64'(start4), 64'(e4_m.start));
                    for (int j = 0; j < 4; j++) check("p4_lane", 64'(out4[j]), 64'(e4_m.lanes[j]));
                end
            end else if (!vout4) begin
                check("p4_idle_start", 64'(start4), 64'(0));
                for (int j = 0; j < 4; j++) check("p4_idle_lane", 64'(out4[j]), 64'(0));
            end
        end
    end

    exp_t e32_m;
    bit   ev32;
    always @(negedge clk) begin
        if (mon_en) begin
            ev32 = (q32.size() > 0) && (int'(q32[0].due) == cyc);
            check("p32_valid_out", 64'(vout32), 64'(ev32));
            if (ev32) begin
                e32_m = q32.pop_front();
                if (vout32) begin
                    check("p32_block_start", 64'(start32), 64'(e32_m.start));
                    for (int j = 0; j < 32; j++) check("p32_lane", 64'(out32[j]), 64'(e32_m.lanes[j]));
                end
            end else if (!vout32) begin
                check("p32_idle_start", 64'(start32), 64'(0));
                for (int j = 0; j < 32; j++) check("p32_idle_lane", 64'(out32[j]), 64'(0));
            end
        end
    end

    initial begin
        rst4  = 1'b1;
        vin4  = 1'b0;
        rst32 = 1'b1;
        vin32 = 1'b0;
        for (int l = 0; l < 4; l++) in4[l] = '0;
        for (int l = 0; l < 32; l++) in32[l] = '0;
        repeat (2) @(posedge clk);
        #2;
        rst4   = 1'b0;
        rst32  = 1'b0;
        mon_en = 1'b1;
        idle4(2);

        // Single block, then idle.
        for (int r = 0; r < 4; r++) step4(1'b1, 1'b0, 1'b0, DW'(16 * r));
        idle4(8);

        // Same block with a two-cycle gap between beats 1 and 2.
        for (int r = 0; r < 2; r++) step4(1'b1, 1'b0, 1'b0, DW'(16 * r));
        idle4(2);
        for (int r = 2; r < 4; r++) step4(1'b1, 1'b0, 1'b0, DW'(16 * r));
        idle4(8);

        // Three blocks at full rate.
        for (int b = 0; b < 3; b++)
            for (int r = 0; r < 4; r++) step4(1'b1, 1'b0, 1'b0, DW'(256 * b + 16 * r));
        idle4(8);

        // Reset while output beat 2 is on the bus, then a fresh block.
        for (int r = 0; r < 4; r++) step4(1'b1, 1'b0, 1'b0, DW'(500 + 16 * r));
        idle4(3);
        step4(1'b0, 1'b1, 1'b0, '0);
        for (int r = 0; r < 4; r++) step4(1'b1, 1'b0, 1'b0, DW'(1000 + 16 * r));
        idle4(8);

        // Partial block dropped by a reset that coincides with a valid beat.
        for (int r = 0; r < 3; r++) step4(1'b1, 1'b0, 1'b0, DW'(2000 + 16 * r));
        step4(1'b1, 1'b1, 1'b0, DW'(2048));
        for (int r = 0; r < 4; r++) step4(1'b1, 1'b0, 1'b0, DW'(3000 + 16 * r));
        idle4(8);

        // Random traffic with gaps and occasional resets.
        repeat (400) step4($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 2, 1'b1, '0);
        idle4(8);

        // PARA=32: one deterministic block, then two random blocks back to back.
        for (int r = 0; r < 32; r++) step32(1'b1, 1'b0, DW'(32 * r));
        for (int r = 0; r < 64; r++) step32(1'b1, 1'b1, '0);
        repeat (40) step32(1'b0, 1'b0, '0);

        check("p4_queue_empty", 64'(q4.size()), 64'(0));
        check("p32_queue_empty", 64'(q32.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spn_block_transpose.md
Name: spn_block_transpose

Overview:
- Streaming PARA x PARA block transposer that undoes the lane/time permutation performed by the spn stage, so lane-parallel results return to natural order for the next CNN layer.
- Accepts PARA-lane words under a valid_in qualifier and collects PARA valid beats into one block.
- Emits the transposed block as a contiguous PARA-beat burst qualified by valid_out.
- Double-buffered (ping-pong), so input streams continuously with no backpressure.

Parameters:
- DATA_WIDTH, 32, width of each lane word.
- PARA, 32, lanes per beat and beats per block; power of two, >= 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- input_stream  input  DATA_WIDTH x [PARA-1:0] (unpacked array)  lane data, sampled when valid_in=1.
- valid_in  input  1  qualifies input_stream in the same cycle.
- output_stream  output  DATA_WIDTH x [PARA-1:0] (unpacked array)  transposed lane data, registered.
- valid_out  output  1  qualifies output_stream, registered.
- block_start  output  1  high with the first beat (column 0) of each output burst.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: valid_out=0, block_start=0, all output_stream lanes=0, wr_cnt=0, wr_bank=0, rd_cnt=0, read FSM=IDLE. Buffer RAM contents are not cleared.
- Write side:
  - On each cycle with valid_in=1, store input_stream[l] into bank[wr_bank][row=wr_cnt][col=l] for all l, then increment wr_cnt.
  - When wr_cnt reaches PARA-1 and a beat is accepted: wr_cnt wraps to 0, wr_bank toggles, and a one-cycle bank_full pulse is raised for the bank just completed.
  - Gaps (valid_in=0) are allowed anywhere; wr_cnt holds during gaps.
- Read FSM, states IDLE and DRAIN:
  - IDLE -> DRAIN on bank_full: latch rd_bank = completed bank, rd_cnt=0.
  - DRAIN: each cycle, register output_stream[j] = bank[rd_bank][row=j][col=rd_cnt] for all j, set valid_out=1, increment rd_cnt.
  - block_start=1 only on the beat where rd_cnt=0.
  - After the beat with rd_cnt=PARA-1: go to IDLE, unless bank_full is asserted in that same cycle, in which case restart DRAIN on the other bank with no bubble.
- Mapping: output beat k, lane j = input beat j (of the block), lane k.
- Latency: if the last beat of a block is accepted at rising edge t, column 0 is visible with valid_out=1 after edge t+1. Columns 1..PARA-1 follow on consecutive cycles with no gaps.
- Output when idle: whenever valid_out=0, output_stream is driven to all-zero.
- Overlap: a block needs >= PARA cycles to fill and a drain takes exactly PARA cycles. The write bank is therefore never the bank being drained, and no overflow is possible at full rate.
- Full-rate input gives continuous output: valid_out stays high indefinitely after an initial latency of PARA+1 cycles.
- Partial block at end of stream: it stays buffered and produces no output until completed. There is no flush port; upstream pads with zero beats.
- Reset mid-operation: any partial write block and any in-progress drain are dropped. valid_out is low in the cycle after the rst edge, and the first valid beat after reset starts a new block at row 0.
- Simultaneous valid_in and rst: reset wins and the beat is discarded.
- Widths: pure data movement, no arithmetic; lane words pass bit-exact.

Test Plan (bench at PARA=4, DATA_WIDTH=32 unless noted):
- Single block: 4 consecutive beats, beat r lane l = 16*r+l; then idle.
  - Required: valid_out high for exactly 4 cycles, starting 1 cycle after the last input edge.
  - Beat k = {k, 16+k, 32+k, 48+k} (lane 0..3); block_start high on beat 0 only.
- Gapped input: same 4 beats with valid_in low on 2 cycles between beats 1 and 2.
  - Required: output identical to the single-block case.
  - Burst contiguous; starts 1 cycle after the 4th valid beat.
- Back-to-back full rate: 3 blocks (12 beats), block b beat r lane l = 256*b+16*r+l.
  - Required: 12 contiguous output beats with no bubble between blocks.
  - block_start high at beats 0, 4, 8; each block correctly transposed.
- Reset mid-drain: assert rst for 1 cycle during output beat 2 of a block, then send a fresh block with values +1000.
  - Required: valid_out=0 after the reset edge and outputs zero.
  - Next burst contains only the +1000 block, transposed.
- Partial block plus reset: send 3 beats, pulse rst, then send a full 4-beat block.
  - Required: exactly one 4-beat burst, matching the new block only.
- PARA=32 regression: 32 beats with beat r lane l = 32*r+l.
  - Required: output beat k lane j = 32*j+k; 32 contiguous valid beats; latency 1 cycle.
